vertical_input_distributor: RTL and testbench

- Inbound counterpart of the vertical output selector: routes north/west/east pad inputs of one pad group to the macro slot chosen by the active configuration.
- Every non-selected slot receives zero.
- Pad inputs are synchronized and outputs are registered.
- Configuration changes use a valid/ready handshake and a quiesce (drain) window, so macros never see a partial or glitching switch.

---
 rtl/vertical_input_distributor.sv | 185 ++++++++++++++++++
 tb/tb_vertical_input_distributor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vertical_input_distributor.sv
// Inbound pad-group router: synchronizes north/west/east pad inputs and steers them to the
// macro slot selected by the active configuration. Optional macro: VERT_IN_DRAIN_HOLD_EN.
module vertical_input_distributor #(
  parameter int unsigned n              = 2,
  parameter int unsigned position       = 0,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned QUIESCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cfg_in,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [3:0]  cfg_active,
  output logic        cfg_error,
  output logic        switching,
  input  logic [9:0]  north_i,
  input  logic [13:0] west_i,
  input  logic [13:0] east_i,
  output logic [9:0]  north_i_buf [0:n-1],
  output logic [13:0] west_i_buf  [0:n],
  output logic [13:0] east_i_buf  [0:n]
);

  localparam int unsigned PadW = 38;

  // cfg -> select table, two bits per cfg code, code 0 in the low bits.
  localparam logic [7:0] SelTable = (position == 0) ? 8'b10_01_10_00 :
                                    (position == 1) ? 8'b01_01_00_00 :
                                                      8'b01_10_00_10;

  if (n != 2) begin : gen_bad_n
    $error("vertical_input_distributor: only n == 2 is supported");
  end
  if (position > 2) begin : gen_bad_position
    $error("vertical_input_distributor: position must be 0..2");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : gen_bad_sync
    $error("vertical_input_distributor: SYNC_STAGES must be 1..3");
  end
  if (QUIESCE_CYCLES < 1 || QUIESCE_CYCLES > 15) begin : gen_bad_quiesce
    $error("vertical_input_distributor: QUIESCE_CYCLES must be 1..15");
  end

  typedef enum logic [1:0] {StActive, StDrain, StSwitch} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cfg_active_q, cfg_active_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  sel_d;

  logic [PadW-1:0] sync_q [SYNC_STAGES];
  logic [9:0]      north_s;
  logic [13:0]     west_s, east_s;

  logic [9:0]  north_q [0:n-1];
  logic [9:0]  north_d [0:n-1];
  logic [13:0] west_q  [0:n];
  logic [13:0] west_d  [0:n];
  logic [13:0] east_q  [0:n];
  logic [13:0] east_d  [0:n];

  // Synchronizer chains run regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {north_i, west_i, east_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {north_s, west_s, east_s} = sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StActive;
      cfg_active_q <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_active_q <= cfg_active_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    cfg_active_d = cfg_active_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    unique case (state_q)
      StActive: begin
        if (cfg_valid) begin
          if (cfg_in > 4'd3) begin
            err_d = 1'b1;
          end else if (cfg_in != cfg_active_q) begin
            pending_d = cfg_in;
            cnt_d     = 4'(QUIESCE_CYCLES - 1);
            state_d   = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_q == 4'd0) begin
          state_d = StSwitch;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSwitch: begin
        cfg_active_d = pending_q;
        state_d      = StActive;
      end
      default: state_d = StActive;
    endcase
  end

  assign sel_d = SelTable[2*cfg_active_d[1:0] +: 2];

  // Output logic; buffer next values follow the next state so gating lands on the
  // first DRAIN cycle and the new slot is live on the first ACTIVE cycle.
  always_comb begin
    cfg_ready = (state_q == StActive) && !rst;
    switching = (state_q == StDrain) || (state_q == StSwitch);
    for (int s = 0; s < n; s++) north_d[s] = '0;
    for (int s = 0; s <= n; s++) begin
      west_d[s] = '0;
      east_d[s] = '0;
    end
    if (state_d == StActive) begin
      for (int s = 0; s < n; s++) begin
        if (sel_d[0] == 1'(s)) north_d[s] = north_s;
      end
      for (int s = 0; s <= n; s++) begin
        if (sel_d == 2'(s)) begin
          west_d[s] = west_s;
          east_d[s] = east_s;
        end
      end
    end
`ifdef VERT_IN_DRAIN_HOLD_EN
    else begin
      // Non-selected slots are already zero, so holding every slot holds only the old one.
      for (int s = 0; s < n; s++) north_d[s] = north_q[s];
      for (int s = 0; s <= n; s++) begin
        west_d[s] = west_q[s];
        east_d[s] = east_q[s];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < n; s++) north_q[s] <= '0;
      for (int s = 0; s <= n; s++) begin
        west_q[s] <= '0;
        east_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < n; s++) north_q[s] <= north_d[s];
      for (int s = 0; s <= n; s++) begin
        west_q[s] <= west_d[s];
        east_q[s] <= east_d[s];
      end
    end
  end

  assign cfg_active  = cfg_active_q;
  assign cfg_error   = err_q;
  assign north_i_buf = north_q;
  assign west_i_buf  = west_q;
  assign east_i_buf  = east_q;

endmodule

// File: tb/tb_vertical_input_distributor.sv
// Directed bench for vertical_input_distributor at position 0, SYNC_STAGES 2, QUIESCE_CYCLES 4.
module tb_vertical_input_distributor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_active;
  logic        cfg_error;
  logic        switching;
  logic [9:0]  north_i;
  logic [13:0] west_i;
  logic [13:0] east_i;
  logic [9:0]  north_i_buf [0:1];
  logic [13:0] west_i_buf  [0:2];
  logic [13:0] east_i_buf  [0:2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vertical_input_distributor #(
    .n(2),
    .position(0),
    .SYNC_STAGES(2),
    .QUIESCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_in(cfg_in),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_active(cfg_active),
    .cfg_error(cfg_error),
    .switching(switching),
    .north_i(north_i),
    .west_i(west_i),
    .east_i(east_i),
    .north_i_buf(north_i_buf),
    .west_i_buf(west_i_buf),
    .east_i_buf(east_i_buf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_bufs();
    return {north_i_buf[0], north_i_buf[1], west_i_buf[0], west_i_buf[1], west_i_buf[2],
            east_i_buf[0], east_i_buf[1], east_i_buf[2]};
  endfunction

  initial begin
    rst = 1'b1; cfg_in = '0; cfg_valid = 1'b0;
    north_i = '0; west_i = '0; east_i = '0;
    step();
    step();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_active", cfg_active, 0);
    chk("rst_switching", switching, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_bufs", all_bufs(), 0);

    rst = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1);

    // Latency: pad -> buf in SYNC_STAGES+1 = 3 cycles.
    west_i = 14'h2AAA; east_i = 14'h1555; north_i = 10'h3FF;
    step();
    step();
    chk("lat_not_early", west_i_buf[0], 0);
    step();
    chk("lat_west0", west_i_buf[0], 14'h2AAA);
    chk("lat_east0", east_i_buf[0], 14'h1555);
    chk("lat_north0", north_i_buf[0], 10'h3FF);
    chk("lat_north1", north_i_buf[1], 0);
    chk("lat_others", {west_i_buf[1], west_i_buf[2], east_i_buf[1], east_i_buf[2]}, 0);

    // Switch to cfg 1 (select 2); a request made during drain must be dropped.
    cfg_valid = 1'b1; cfg_in = 4'd1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_switching_%0d", i), switching, 1);
      chk($sformatf("drain_ready_%0d", i), cfg_ready, 0);
      chk($sformatf("drain_bufs_%0d", i), all_bufs(), 0);
      if (i == 1) begin
        cfg_valid = 1'b1; cfg_in = 4'd2;
      end
      if (i == 2) cfg_valid = 1'b0;
      step();
    end
    chk("sw1_switching", switching, 0);
    chk("sw1_active", cfg_active, 1);
    chk("sw1_west2", west_i_buf[2], 14'h2AAA);
    chk("sw1_east2", east_i_buf[2], 14'h1555);
    chk("sw1_north0", north_i_buf[0], 10'h3FF);
    chk("sw1_west0", west_i_buf[0], 0);
    chk("sw1_north1", north_i_buf[1], 0);
    step();
    chk("ignored_active", cfg_active, 1);
    chk("ignored_switching", switching, 0);

    // Move to cfg 3, then re-request cfg 3 as a no-op.
    cfg_valid = 1'b1; cfg_in = 4'd3;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    chk("sw3_active", cfg_active, 3);
    chk("sw3_west2", west_i_buf[2], 14'h2AAA);
    cfg_valid = 1'b1; cfg_in = 4'd3;
    #1;
    chk("noop_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("noop_switching", switching, 0);
    chk("noop_ready_after", cfg_ready, 1);
    chk("noop_active", cfg_active, 3);
    chk("noop_west2", west_i_buf[2], 14'h2AAA);
    step();
    chk("noop_switching_late", switching, 0);

    // Out-of-range request.
    cfg_valid = 1'b1; cfg_in = 4'h9;
    step();
    cfg_valid = 1'b0;
    chk("err_pulse", cfg_error, 1);
    chk("err_switching", switching, 0);
    chk("err_active", cfg_active, 3);
    step();
    chk("err_clear", cfg_error, 0);

    // New data, cfg 2 -> select 1 (north slot 1).
    west_i = 14'h0F0F; east_i = 14'h3C3C; north_i = 10'h155;
    cfg_valid = 1'b1; cfg_in = 4'd2;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    chk("sw2_active", cfg_active, 2);
    chk("sw2_west1", west_i_buf[1], 14'h0F0F);
    chk("sw2_east1", east_i_buf[1], 14'h3C3C);
    chk("sw2_north1", north_i_buf[1], 10'h155);
    chk("sw2_others", {west_i_buf[0], west_i_buf[2], north_i_buf[0]}, 0);

    // Reset during the second drain cycle discards the pending cfg.
    cfg_valid = 1'b1; cfg_in = 4'd0;
    step();
    cfg_valid = 1'b0;
    chk("rd_drain1", switching, 1);
    step();
    chk("rd_drain2", switching, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rd_active", cfg_active, 0);
    chk("rd_switching", switching, 0);
    chk("rd_ready", cfg_ready, 1);
    chk("rd_bufs", all_bufs(), 0);
    step();
    step();
    chk("rd_not_early", west_i_buf[0], 0);
    step();
    chk("rd_west0", west_i_buf[0], 14'h0F0F);
    chk("rd_east0", east_i_buf[0], 14'h3C3C);
    chk("rd_north0", north_i_buf[0], 10'h155);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
